// File: rtl/spi_slave_trx_char.sv
// SPI slave character transceiver, fully in the S_SYSCLK domain (SCK/CS_N/MOSI are oversampled).
// Optional S_TX_UNDERRUN output is enabled by defining SPI_SLAVE_UNDERRUN_EN.
module spi_slave_trx_char #(
    parameter int unsigned CHAR_NBITS  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESETN,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_REV,
    input  logic [3:0]            S_CHAR_LEN,
    input  logic [CHAR_NBITS-1:0] S_WCHAR,
    input  logic                  S_WCHAR_LD,
    output logic                  S_TX_FULL,
    output logic [CHAR_NBITS-1:0] S_RCHAR,
    output logic                  S_RCHAR_VALID,
    output logic                  S_FRAME_ERR,
    input  logic                  S_SPI_SCK,
    input  logic                  S_SPI_CS_N,
    input  logic                  S_SPI_MOSI,
    output logic                  S_SPI_MISO,
    output logic                  S_SPI_MISO_OE
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic                  S_TX_UNDERRUN
`endif
);

    localparam int unsigned IdxW = $clog2(CHAR_NBITS);

    typedef enum logic [1:0] {StIdle, StLoad, StActive} state_e;

    // SCK is synchronized after normalising by CPOL, so its idle level is always 0.
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], S_SPI_SCK ^ S_CPOL};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], S_SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], S_SPI_MOSI};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign lead_edge   = sck_s & ~sck_prev_q;
    assign trail_edge  = ~sck_s & sck_prev_q;
    assign sample_edge = S_CPHA ? trail_edge : lead_edge;
    assign shift_edge  = S_CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_s & cs_prev_q;

    state_e                state_q, state_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d, tx_idx_q, tx_idx_d;
    logic [CHAR_NBITS-1:0] tx_q, tx_d, rx_q, rx_d, rchar_q, rchar_d, hold_q;
    logic                  full_q, miso_q, miso_d;
    logic                  rvalid_q, rvalid_d, ferr_q, ferr_d;
    logic                  load_xfer, reload_xfer, sample_take;

    logic [5:0]            n_bits, cnt_inc;
    logic [IdxW-1:0]       rx_pos, tx_pos, first_pos;
    logic [CHAR_NBITS-1:0] load_val;

    assign n_bits    = (S_CHAR_LEN == 4'd0) ? 6'd32 : {2'b00, S_CHAR_LEN} + 6'd1;
    assign cnt_inc   = bit_cnt_q + 6'd1;
    assign rx_pos    = IdxW'(S_REV ? (n_bits - 6'd1 - bit_cnt_q) : bit_cnt_q);
    assign tx_pos    = IdxW'(S_REV ? (n_bits - 6'd1 - tx_idx_q) : tx_idx_q);
    assign first_pos = IdxW'(S_REV ? (n_bits - 6'd1) : 6'd0);
    assign load_val  = full_q ? hold_q : '1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        miso_d      = miso_q;
        rchar_d     = rchar_q;
        rvalid_d    = 1'b0;
        ferr_d      = 1'b0;
        load_xfer   = 1'b0;
        reload_xfer = 1'b0;
        sample_take = 1'b0;
        if (!S_ENABLE) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            miso_d    = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) state_d = StLoad;
                end
                StLoad: begin
                    if (cs_s) begin
                        state_d = StIdle;
                    end else begin
                        load_xfer = 1'b1;
                        state_d   = StActive;
                    end
                end
                StActive: begin
                    if (cs_s) begin
                        state_d   = StIdle;
                        ferr_d    = (bit_cnt_q != 6'd0);
                        bit_cnt_d = '0;
                        miso_d    = 1'b1;
                    end else if (sample_edge) begin
                        sample_take = 1'b1;
                        rx_d[rx_pos] = mosi_s;
                        if (cnt_inc == n_bits) begin
                            rchar_d     = rx_d;
                            rvalid_d    = 1'b1;
                            reload_xfer = 1'b1;
                        end else begin
                            bit_cnt_d = cnt_inc;
                        end
                    end else if (shift_edge && (S_CPHA || bit_cnt_q != 6'd0)) begin
                        // CPHA=0: the shift edge right after a completed char is skipped.
                        miso_d   = tx_q[tx_pos];
                        tx_idx_d = tx_idx_q + 6'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (load_xfer || reload_xfer) begin
            tx_d      = load_val;
            rx_d      = '0;
            bit_cnt_d = '0;
            tx_idx_d  = S_CPHA ? 6'd0 : 6'd1;
            miso_d    = S_CPHA | load_val[first_pos];
        end
    end

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tx_idx_q  <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            miso_q    <= 1'b1;
            rchar_q   <= '0;
            rvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_idx_q  <= tx_idx_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            miso_q    <= miso_d;
            rchar_q   <= rchar_d;
            rvalid_q  <= rvalid_d;
            ferr_q    <= ferr_d;
        end
    end

    // A load strobe coinciding with a transfer wins: old value shifts out, new one stays held.
    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (S_WCHAR_LD) begin
            hold_q <= S_WCHAR;
            full_q <= 1'b1;
        end else if (load_xfer || reload_xfer) begin
            full_q <= 1'b0;
        end
    end

    always_comb begin
        S_SPI_MISO = 1'b1;
        if (S_ENABLE) begin
            if (state_q == StLoad) S_SPI_MISO = S_CPHA | load_val[first_pos];
            else if (state_q == StActive) S_SPI_MISO = miso_q;
        end
    end

    assign S_SPI_MISO_OE = S_ENABLE & (state_q != StIdle);
    assign S_TX_FULL     = full_q;
    assign S_RCHAR       = rchar_q;
    assign S_RCHAR_VALID = rvalid_q;
    assign S_FRAME_ERR   = ferr_q;

`ifdef SPI_SLAVE_UNDERRUN_EN
    // An empty in-frame reload is only reported once its char actually starts being clocked,
    // so a frame's trailing reload does not raise a spurious pulse.
    logic underrun_q, reload_empty_q;

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            underrun_q     <= 1'b0;
            reload_empty_q <= 1'b0;
        end else begin
            underrun_q <= (load_xfer & ~full_q) | (sample_take & reload_empty_q);
            if (reload_xfer) reload_empty_q <= ~full_q;
            else if (sample_take || state_q != StActive) reload_empty_q <= 1'b0;
        end
    end

    assign S_TX_UNDERRUN = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_trx_char.sv
// Self-checking bench for spi_slave_trx_char: a bit-banged SPI master, a vector table for the
// directed frames, hand sequences for error/reset/enable corners and randomized frames.
module tb_spi_slave_trx_char;

    localparam int H = 5;  // SCK half-period in system clocks

    logic        clk, rstn, enable, cpol, cpha, rev;
    logic [3:0]  char_len;
    logic [31:0] wchar;
    logic        wchar_ld, tx_full;
    logic [31:0] rchar;
    logic        rchar_valid, frame_err;
    logic        sck, cs_n, mosi, miso, miso_oe;

    spi_slave_trx_char dut (
        .S_SYSCLK      (clk),
        .S_RESETN      (rstn),
        .S_ENABLE      (enable),
        .S_CPOL        (cpol),
        .S_CPHA        (cpha),
        .S_REV         (rev),
        .S_CHAR_LEN    (char_len),
        .S_WCHAR       (wchar),
        .S_WCHAR_LD    (wchar_ld),
        .S_TX_FULL     (tx_full),
        .S_RCHAR       (rchar),
        .S_RCHAR_VALID (rchar_valid),
        .S_FRAME_ERR   (frame_err),
        .S_SPI_SCK     (sck),
        .S_SPI_CS_N    (cs_n),
        .S_SPI_MOSI    (mosi),
        .S_SPI_MISO    (miso),
        .S_SPI_MISO_OE (miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor: log every received char and count frame-error pulses.
    logic [31:0] rx_log[$];
    int          ferr_total = 0;
    always @(negedge clk) begin
        if (rchar_valid) rx_log.push_back(rchar);
        if (frame_err) ferr_total++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic pulse_ld(input logic [31:0] v);
        wchar    = v;
        wchar_ld = 1'b1;
        @(negedge clk);
        wchar_ld = 1'b0;
    endtask

    function automatic logic [31:0] mask_of(input int n);
        logic [32:0] one;
        one = 33'd1;
        return (n == 32) ? 32'hFFFF_FFFF : 32'((one << n) - 33'd1);
    endfunction

    // Frame parameters / results shared with the master task
    logic        f_cpol, f_cpha, f_rev, f_preload, f_load1;
    logic [3:0]  f_len;
    int          f_n, f_abort, f_dis_at;
    logic [31:0] f_tx[2], f_mosi[2], f_got[2];
    logic        f_full_before, f_oe_after, f_oe_dis;

    function automatic logic bit_of(input int k, input int i, input int n);
        logic [31:0] v;
        v = f_mosi[k];
        return v[f_rev ? n - 1 - i : i];
    endfunction

    // Bit-banged SPI master: drives one CS_N frame of f_n chars and captures MISO.
    task automatic run_frame();
        int n, total_bits, idx;
        bit stop;
        n = (f_len == 4'd0) ? 32 : int'(f_len) + 1;
        cpol = f_cpol; cpha = f_cpha; rev = f_rev; char_len = f_len;
        sck = f_cpol; cs_n = 1'b1;
        idle(4);
        if (f_preload) pulse_ld(f_tx[0]);
        f_full_before = tx_full;
        f_got[0] = '0;
        f_got[1] = '0;
        f_oe_dis = 1'b0;
        cs_n = 1'b0;
        if (!f_cpha) mosi = bit_of(0, 0, n);
        idle(H);
        total_bits = 0;
        stop = 0;
        for (int k = 0; k < f_n && !stop; k++) begin
            for (int i = 0; i < n && !stop; i++) begin
                idx = f_rev ? n - 1 - i : i;
                if (!f_cpha) begin
                    f_got[k][idx] = miso;
                    sck = ~f_cpol;
                    idle(H);
                    sck = f_cpol;
                    if (i < n - 1) mosi = bit_of(k, i + 1, n);
                    else if (k + 1 < f_n) mosi = bit_of(k + 1, 0, n);
                    idle(H);
                end else begin
                    sck  = ~f_cpol;
                    mosi = bit_of(k, i, n);
                    idle(H);
                    f_got[k][idx] = miso;
                    sck = f_cpol;
                    idle(H);
                end
                total_bits++;
                if (k == 0 && i == 0 && f_n > 1 && f_load1) pulse_ld(f_tx[1]);
                if (total_bits == f_abort) stop = 1;
                if (total_bits == f_dis_at) begin
                    enable = 1'b0;
                    @(negedge clk);
                    f_oe_dis = miso_oe;
                end
            end
        end
        cs_n = 1'b1;
        idle(3);
        f_oe_after = miso_oe;
        idle(6);
    endtask

    typedef struct {
        logic        cpol, cpha, rev;
        logic [3:0]  len;
        int          nchars;
        logic        preload, load1;
        logic [31:0] tx0, tx1, mo0, mo1;
        logic [31:0] em0, em1, er0, er1;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] last_rx;
    int          log0, ferr0, n, nc;
    logic [31:0] m, exp_m[2];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd7,  1, 1'b1, 1'b0, 32'hA5, 32'h0, 32'h3C, 32'h0,
                    32'hA5, 32'h0, 32'h3C, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 4'd15, 1, 1'b1, 1'b0, 32'h1234, 32'h0, 32'hBEEF, 32'h0,
                    32'h1234, 32'h0, 32'hBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd0,  2, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222,
                    32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h1111_1111, 32'h2222_2222,
                    32'hCAFE_F00D, 32'h0BAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd7,  1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5A, 32'h0,
                    32'hFF, 32'h0, 32'h5A, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 4'd4,  1, 1'b1, 1'b0, 32'h1F3, 32'h0, 32'h3E6, 32'h0,
                    32'h13, 32'h0, 32'h06, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 4'd7,  2, 1'b1, 1'b0, 32'h81, 32'h0, 32'h7E, 32'hC3,
                    32'h81, 32'hFF, 32'h7E, 32'hC3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 4'd2,  2, 1'b0, 1'b1, 32'h0, 32'h5, 32'h6, 32'h1,
                    32'h7, 32'h5, 32'h6, 32'h1};

        rstn = 1'b0; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; rev = 1'b0; char_len = 4'd7;
        wchar = '0; wchar_ld = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        f_abort = 0; f_dis_at = 0;
        idle(3);
        check("reset tx_full", tx_full, 0);
        check("reset rchar", rchar, 0);
        check("reset rchar_valid", rchar_valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset miso", miso, 1);
        check("reset miso_oe", miso_oe, 0);
        rstn = 1'b1;
        idle(3);

        foreach (vecs[v]) begin
            f_cpol = vecs[v].cpol; f_cpha = vecs[v].cpha; f_rev = vecs[v].rev;
            f_len = vecs[v].len; f_n = vecs[v].nchars;
            f_preload = vecs[v].preload; f_load1 = vecs[v].load1;
            f_tx[0] = vecs[v].tx0; f_tx[1] = vecs[v].tx1;
            f_mosi[0] = vecs[v].mo0; f_mosi[1] = vecs[v].mo1;
            log0 = rx_log.size(); ferr0 = ferr_total;
            run_frame();
            check($sformatf("v%0d tx_full before cs", v), f_full_before, vecs[v].preload);
            check($sformatf("v%0d miso char0", v), f_got[0], vecs[v].em0);
            check($sformatf("v%0d rchar0", v),
                  (rx_log.size() > log0) ? rx_log[log0] : 32'hDEAD_0000, vecs[v].er0);
            if (vecs[v].nchars > 1) begin
                check($sformatf("v%0d miso char1", v), f_got[1], vecs[v].em1);
                check($sformatf("v%0d rchar1", v),
                      (rx_log.size() > log0 + 1) ? rx_log[log0 + 1] : 32'hDEAD_0001,
                      vecs[v].er1);
            end
            check($sformatf("v%0d valid pulses", v), rx_log.size() - log0, vecs[v].nchars);
            check($sformatf("v%0d frame_err pulses", v), ferr_total - ferr0, 0);
            check($sformatf("v%0d miso_oe after cs", v), f_oe_after, 0);
            last_rx = (vecs[v].nchars > 1) ? vecs[v].er1 : vecs[v].er0;
        end

        // CS_N raised after 5 of 8 bits in mode 2
        f_cpol = 1; f_cpha = 0; f_rev = 0; f_len = 4'd7; f_n = 1; f_preload = 1; f_load1 = 0;
        f_tx[0] = 32'hAB; f_mosi[0] = 32'hF0; f_abort = 5;
        log0 = rx_log.size(); ferr0 = ferr_total;
        run_frame();
        f_abort = 0;
        check("abort frame_err pulses", ferr_total - ferr0, 1);
        check("abort valid pulses", rx_log.size() - log0, 0);
        check("abort rchar unchanged", rchar, last_rx);
        check("abort miso_oe after cs", f_oe_after, 0);

        // Holding register overwrite: last load wins
        pulse_ld(32'h11);
        f_cpol = 0; f_cpha = 0; f_rev = 0; f_len = 4'd7; f_n = 1; f_preload = 1;
        f_tx[0] = 32'h77; f_mosi[0] = 32'h01;
        run_frame();
        check("overwrite miso", f_got[0], 32'h77);

        // Disable mid-frame, then load while disabled and re-enable
        f_tx[0] = 32'h3C; f_mosi[0] = 32'hC3; f_dis_at = 3;
        log0 = rx_log.size(); ferr0 = ferr_total;
        run_frame();
        f_dis_at = 0;
        check("disable miso_oe", f_oe_dis, 0);
        check("disable valid pulses", rx_log.size() - log0, 0);
        check("disable frame_err pulses", ferr_total - ferr0, 0);
        pulse_ld(32'h42);
        enable = 1'b1;
        f_preload = 0; f_mosi[0] = 32'h99;
        log0 = rx_log.size();
        run_frame();
        check("held across disable miso", f_got[0], 32'h42);
        check("after enable rchar",
              (rx_log.size() > log0) ? rx_log[log0] : 32'hDEAD_0002, 32'h99);

        // Reset asserted mid-character
        cpol = 0; cpha = 0; rev = 0; char_len = 4'd7;
        pulse_ld(32'h55);
        cs_n = 1'b0;
        idle(H);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1; idle(H); sck = 1'b0; idle(H);
        end
        rstn = 1'b0;
        #1;
        check("midreset tx_full", tx_full, 0);
        check("midreset rchar", rchar, 0);
        check("midreset rchar_valid", rchar_valid, 0);
        check("midreset frame_err", frame_err, 0);
        check("midreset miso", miso, 1);
        check("midreset miso_oe", miso_oe, 0);
        @(negedge clk);
        cs_n = 1'b1; sck = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(4);
        f_preload = 1; f_tx[0] = 32'h96; f_mosi[0] = 32'h69;
        log0 = rx_log.size();
        run_frame();
        check("post-reset miso", f_got[0], 32'h96);
        check("post-reset rchar",
              (rx_log.size() > log0) ? rx_log[log0] : 32'hDEAD_0003, 32'h69);

        // Randomized frames against the value-level reference model
        for (int r = 0; r < 20; r++) begin
            f_cpol = 1'($urandom_range(0, 1)); f_cpha = 1'($urandom_range(0, 1));
            f_rev = 1'($urandom_range(0, 1)); f_len = 4'($urandom_range(0, 15));
            f_n = $urandom_range(1, 2);
            f_preload = 1'($urandom_range(0, 1)); f_load1 = 1'($urandom_range(0, 1));
            f_tx[0] = $urandom; f_tx[1] = $urandom;
            f_mosi[0] = $urandom; f_mosi[1] = $urandom;
            n = (f_len == 4'd0) ? 32 : int'(f_len) + 1;
            m = mask_of(n);
            exp_m[0] = f_preload ? (f_tx[0] & m) : m;
            exp_m[1] = f_load1 ? (f_tx[1] & m) : m;
            log0 = rx_log.size(); ferr0 = ferr_total;
            run_frame();
            nc = f_n;
            for (int k = 0; k < nc; k++) begin
                check($sformatf("rnd%0d miso char%0d", r, k), f_got[k], exp_m[k]);
                check($sformatf("rnd%0d rchar%0d", r, k),
                      (rx_log.size() > log0 + k) ? rx_log[log0 + k] : ~(f_mosi[k] & m),
                      f_mosi[k] & m);
            end
            check($sformatf("rnd%0d valid pulses", r), rx_log.size() - log0, nc);
            check($sformatf("rnd%0d frame_err pulses", r), ferr_total - ferr0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
